ex_flush_ctrl: RTL and testbench

Exception/ERET/interrupt sequencer sitting beside the WB stage and CP0. It detects a committing exception, ERET or pending interrupt on the instruction in WB, and issues one CP0 update strobe. It then holds a pipeline-wide flush for a programmable number of cycles and delivers a redirect PC to the fetch stage through a valid/ready handshake. It is the single owner of flush and refetch sequencing in the core.

---
 rtl/mycpu_pkg.sv | 32 +++
 rtl/ex_event_sel.sv | 41 ++++
 rtl/ex_flush_ctrl.sv | 115 +++++++++++
 tb/tb_ex_flush_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared core definitions: CP0 exception codes, the flush sequencer state
// type, and the CP0 strobe bus layout.
package mycpu_pkg;

   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0a;
   localparam logic [4:0] EXC_OV   = 5'h0c;

   localparam logic [31:0] EX_ENTRY_DEF = 32'hbfc00380;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLUSH,
      S_REDIRECT
   } flush_state_t;

   typedef struct packed {
      logic        ex_we;
      logic        eret_we;
      logic [4:0]  excode;
      logic [31:0] epc;
      logic        bd;
      logic [31:0] badvaddr;
   } cp0_stb_t;

   localparam int CP0_STB_W = $bits(cp0_stb_t);

endpackage

// File: rtl/ex_event_sel.sv
// Priority select of exception / interrupt / ERET on the WB instruction and
// assembly of the one-cycle CP0 strobe bus.
module ex_event_sel
   import mycpu_pkg::*;
(
   input  logic                 en,
   input  logic                 ws_valid,
   input  logic                 ws_ex,
   input  logic [4:0]           ws_excode,
   input  logic                 ws_eret,
   input  logic                 ws_bd,
   input  logic [31:0]          ws_pc,
   input  logic [31:0]          ws_badvaddr,
   input  logic                 int_pending,
   output logic                 ex_ev,
   output logic                 int_ev,
   output logic                 eret_ev,
   output logic [CP0_STB_W-1:0] stb
);

   cp0_stb_t s;

   always_comb begin
      ex_ev   = en & ws_valid & ws_ex;
      int_ev  = en & ws_valid & ~ws_ex & int_pending;
      eret_ev = en & ws_valid & ~ws_ex & ~int_pending & ws_eret;
      s       = '0;
      if (ex_ev | int_ev | eret_ev) begin
         s.ex_we    = ex_ev | int_ev;
         s.eret_we  = eret_ev;
         s.excode   = ex_ev ? ws_excode : EXC_INT;
         // Delay-slot instructions report the branch PC; wraps mod 2^32.
         s.epc      = ws_bd ? (ws_pc - 32'd4) : ws_pc;
         s.bd       = ws_bd;
         s.badvaddr = ws_badvaddr;
      end
   end

   assign stb = s;

endmodule

// File: rtl/ex_flush_ctrl.sv
// Exception/ERET/interrupt sequencer: one CP0 strobe, a programmable-length
// pipeline flush, then a redirect PC handed to fetch via valid/ready.
module ex_flush_ctrl
   import mycpu_pkg::*;
#(
   parameter logic [31:0] EX_ENTRY     = EX_ENTRY_DEF,
   parameter int          FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ws_valid,
   input  logic        ws_ex,
   input  logic [4:0]  ws_excode,
   input  logic        ws_eret,
   input  logic        ws_bd,
   input  logic [31:0] ws_pc,
   input  logic [31:0] ws_badvaddr,
   input  logic [31:0] cp0_epc,
   input  logic        cp0_int_pending,
   output logic        int_kill,
   output logic        cp0_ex_we,
   output logic        cp0_eret_we,
   output logic [4:0]  cp0_excode,
   output logic [31:0] cp0_epc_wdata,
   output logic        cp0_bd,
   output logic [31:0] cp0_badvaddr,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        fs_redirect_ready
);

   localparam int             CNT_W    = $clog2(FLUSH_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   flush_state_t     state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [31:0]      rpc_nx;
   logic             ex_ev, int_ev, eret_ev, any_ev;
   logic [CP0_STB_W-1:0] stb_bus;
   cp0_stb_t         stb;

   // Events are only looked at while idle; reset also silences the strobes.
   ex_event_sel u_sel (
      .en          (resetn & (state == S_IDLE)),
      .ws_valid    (ws_valid),
      .ws_ex       (ws_ex),
      .ws_excode   (ws_excode),
      .ws_eret     (ws_eret),
      .ws_bd       (ws_bd),
      .ws_pc       (ws_pc),
      .ws_badvaddr (ws_badvaddr),
      .int_pending (cp0_int_pending),
      .ex_ev       (ex_ev),
      .int_ev      (int_ev),
      .eret_ev     (eret_ev),
      .stb         (stb_bus)
   );

   assign stb           = cp0_stb_t'(stb_bus);
   assign any_ev        = ex_ev | int_ev | eret_ev;
   assign int_kill      = int_ev;
   assign cp0_ex_we     = stb.ex_we;
   assign cp0_eret_we   = stb.eret_we;
   assign cp0_excode    = stb.excode;
   assign cp0_epc_wdata = stb.epc;
   assign cp0_bd        = stb.bd;
   assign cp0_badvaddr  = stb.badvaddr;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         cnt         <= '0;
         redirect_pc <= '0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         redirect_pc <= rpc_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      cnt_nx         = cnt;
      rpc_nx         = redirect_pc;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      case (state)
         S_IDLE: begin
            if (any_ev) begin
               flush  = 1'b1;
               rpc_nx = eret_ev ? cp0_epc : EX_ENTRY;
               if (FLUSH_CYCLES > 1) begin
                  state_nx = S_FLUSH;
                  cnt_nx   = CNT_LOAD;
               end else begin
                  state_nx = S_REDIRECT;
               end
            end
         end
         S_FLUSH: begin
            flush  = 1'b1;
            cnt_nx = cnt - CNT_ONE;
            if (cnt == CNT_ONE) state_nx = S_REDIRECT;
         end
         S_REDIRECT: begin
            redirect_valid = 1'b1;
            if (fs_redirect_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ex_flush_ctrl.sv
// Scoreboard bench: two sequencers (FLUSH_CYCLES 1 and 3) share the WB bus;
// stimulus pushes expected strobes/redirects, a negedge monitor pops and checks.
module tb_ex_flush_ctrl;

   typedef struct packed {
      logic        kill;
      logic        ex_we;
      logic        eret_we;
      logic [4:0]  excode;
      logic [31:0] epc;
      logic        bd;
      logic [31:0] badv;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic [1:0] wv = '0, rdy = 2'b11;
   logic ws_ex = 0, ws_eret = 0, ws_bd = 0, int_p = 0;
   logic [4:0] ws_excode = '0;
   logic [31:0] ws_pc = '0, ws_badv = '0, cp0_epc = '0;

   logic [1:0] ik, exw, erw, bdw, flw, rvw;
   logic [1:0][4:0] exc;
   logic [1:0][31:0] epcw, bvw, rpcw;

   int total = 0, bad = 0;
   exp_t sq0[$], sq1[$];
   logic [31:0] rq0[$], rq1[$];
   bit trk[2];
   int lat[2], fl[2];

   always #5 clk = ~clk;

   ex_flush_ctrl #(.FLUSH_CYCLES(1)) u1 (
      .clk(clk), .resetn(resetn), .ws_valid(wv[0]), .ws_ex(ws_ex), .ws_excode(ws_excode),
      .ws_eret(ws_eret), .ws_bd(ws_bd), .ws_pc(ws_pc), .ws_badvaddr(ws_badv),
      .cp0_epc(cp0_epc), .cp0_int_pending(int_p), .int_kill(ik[0]), .cp0_ex_we(exw[0]),
      .cp0_eret_we(erw[0]), .cp0_excode(exc[0]), .cp0_epc_wdata(epcw[0]), .cp0_bd(bdw[0]),
      .cp0_badvaddr(bvw[0]), .flush(flw[0]), .redirect_valid(rvw[0]), .redirect_pc(rpcw[0]),
      .fs_redirect_ready(rdy[0]));

   ex_flush_ctrl #(.FLUSH_CYCLES(3)) u3 (
      .clk(clk), .resetn(resetn), .ws_valid(wv[1]), .ws_ex(ws_ex), .ws_excode(ws_excode),
      .ws_eret(ws_eret), .ws_bd(ws_bd), .ws_pc(ws_pc), .ws_badvaddr(ws_badv),
      .cp0_epc(cp0_epc), .cp0_int_pending(int_p), .int_kill(ik[1]), .cp0_ex_we(exw[1]),
      .cp0_eret_we(erw[1]), .cp0_excode(exc[1]), .cp0_epc_wdata(epcw[1]), .cp0_bd(bdw[1]),
      .cp0_badvaddr(bvw[1]), .flush(flw[1]), .redirect_valid(rvw[1]), .redirect_pc(rpcw[1]),
      .fs_redirect_ready(rdy[1]));

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] ev);
      total++;
      if (act !== ev) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, ev);
      end
   endtask

   function automatic exp_t mk(input logic kill, input logic xw, input logic ew,
                               input logic [4:0] code, input logic [31:0] epc,
                               input logic bd, input logic [31:0] badv);
      exp_t e;
      e = {kill, xw, ew, code, epc, bd, badv};
      return e;
   endfunction

   function automatic int fc(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic mon(input int k);
      exp_t e, a;
      logic [31:0] r;
      bit have;
      if (exw[k] | erw[k]) begin
         have = (k == 0) ? (sq0.size() != 0) : (sq1.size() != 0);
         if (!have) begin
            total++; bad++;
            $display("FAIL unexpected_strobe dut%0d actual=%0b%0b required=00", k, exw[k], erw[k]);
         end else begin
            if (k == 0) e = sq0.pop_front(); else e = sq1.pop_front();
            a = {ik[k], exw[k], erw[k], exc[k], epcw[k], bdw[k], bvw[k]};
            if (e.eret_we) a.excode = e.excode;
            chk($sformatf("strobe_dut%0d", k), 128'(a), 128'(e));
            chk($sformatf("flush_at_T_dut%0d", k), 128'(flw[k]), 128'(1));
         end
         trk[k] = 1; lat[k] = 0; fl[k] = int'(flw[k]);
      end else if (trk[k]) begin
         if (!rvw[k]) begin
            lat[k]++;
            fl[k] += int'(flw[k]);
         end else begin
            chk($sformatf("redirect_latency_dut%0d", k), 128'(lat[k]), 128'(fc(k) - 1));
            chk($sformatf("flush_len_dut%0d", k), 128'(fl[k]), 128'(fc(k)));
            trk[k] = 0;
         end
      end
      if (rvw[k]) begin
         chk($sformatf("redirect_flush_int_kill_dut%0d", k), 128'({flw[k], ik[k]}), 128'(0));
         have = (k == 0) ? (rq0.size() != 0) : (rq1.size() != 0);
         if (!have) begin
            total++; bad++;
            $display("FAIL unexpected_redirect dut%0d actual=%0h", k, rpcw[k]);
         end else begin
            r = (k == 0) ? rq0[0] : rq1[0];
            chk($sformatf("redirect_pc_dut%0d", k), 128'(rpcw[k]), 128'(r));
            if (rdy[k]) begin
               if (k == 0) void'(rq0.pop_front()); else void'(rq1.pop_front());
            end
         end
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!resetn) trk[k] = 0;
         else mon(k);
      end
   end

   task automatic drive(input logic [1:0] m, input logic ex, input logic [4:0] code,
                        input logic eret, input logic ip, input logic bd,
                        input logic [31:0] pc, input logic [31:0] epc_in, input logic [31:0] badv);
      wv = m; ws_ex = ex; ws_excode = code; ws_eret = eret; int_p = ip;
      ws_bd = bd; ws_pc = pc; cp0_epc = epc_in; ws_badv = badv;
   endtask

   task automatic clear_in();
      drive(2'b00, 0, 5'h00, 0, 0, 0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic issue(input logic [1:0] m, input logic ex, input logic [4:0] code,
                        input logic eret, input logic ip, input logic bd,
                        input logic [31:0] pc, input logic [31:0] epc_in, input logic [31:0] badv,
                        input exp_t e, input logic [31:0] rd);
      if (m[0]) begin sq0.push_back(e); rq0.push_back(rd); end
      if (m[1]) begin sq1.push_back(e); rq1.push_back(rd); end
      @(posedge clk); #1;
      drive(m, ex, code, eret, ip, bd, pc, epc_in, badv);
      @(posedge clk); #1;
      clear_in();
   endtask

   task automatic wait_done();
      int n = 0;
      while ((sq0.size() + sq1.size() + rq0.size() + rq1.size()) != 0 && n < 60) begin
         @(posedge clk); n++;
      end
      if (n >= 60) begin
         total++; bad++;
         $display("FAIL timeout_wait_done pending=%0d required=0",
                  sq0.size() + sq1.size() + rq0.size() + rq1.size());
         sq0.delete(); sq1.delete(); rq0.delete(); rq1.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_rv(input int k);
      int n = 0;
      while (rvw[k] !== 1'b1 && n < 40) begin
         @(negedge clk); n++;
      end
      if (n >= 40) begin
         total++; bad++;
         $display("FAIL timeout_redirect_valid dut%0d actual=0 required=1", k);
      end
   endtask

   task automatic chk_zero(input string nm);
      for (int k = 0; k < 2; k++)
         chk($sformatf("%s_dut%0d", nm, k),
             128'({ik[k], exw[k], erw[k], exc[k], epcw[k], bdw[k], bvw[k], flw[k], rvw[k], rpcw[k]}),
             128'(0));
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset_outputs");
      resetn = 1'b1;

      // AdEL, not in delay slot
      issue(2'b11, 1, 5'h04, 0, 0, 0, 32'h8000_1000, 32'h0, 32'h8000_1001,
            mk(0, 1, 0, 5'h04, 32'h8000_1000, 0, 32'h8000_1001), 32'hbfc0_0380);
      wait_done();

      // delay-slot exception; fetch stalls the redirect for 4 cycles while WB keeps raising events
      rdy = 2'b01;
      issue(2'b11, 1, 5'h04, 0, 0, 1, 32'h8000_1000, 32'h0, 32'h0,
            mk(0, 1, 0, 5'h04, 32'h8000_0ffc, 1, 32'h0), 32'hbfc0_0380);
      wait_rv(1);
      drive(2'b10, 1, 5'h0c, 1, 1, 0, 32'h8000_7000, 32'h1234_5678, 32'h0);
      repeat (4) @(posedge clk);
      #1;
      clear_in();
      rdy = 2'b11;
      wait_done();

      // ERET
      issue(2'b11, 0, 5'h00, 1, 0, 0, 32'h8000_1234, 32'h8000_2000, 32'h0,
            mk(0, 0, 1, 5'h00, 32'h8000_1234, 0, 32'h0), 32'h8000_2000);
      wait_done();

      // interrupt beats ERET
      issue(2'b11, 0, 5'h00, 1, 1, 0, 32'h8000_3000, 32'h8000_2000, 32'h0,
            mk(1, 1, 0, 5'h00, 32'h8000_3000, 0, 32'h0), 32'hbfc0_0380);
      wait_done();

      // exception beats ERET and interrupt
      issue(2'b11, 1, 5'h0a, 1, 1, 0, 32'h8000_4000, 32'h8000_2000, 32'h0,
            mk(0, 1, 0, 5'h0a, 32'h8000_4000, 0, 32'h0), 32'hbfc0_0380);
      wait_done();

      // EPC wrap
      issue(2'b11, 1, 5'h0c, 0, 0, 1, 32'h0000_0000, 32'h0, 32'hdead_beef,
            mk(0, 1, 0, 5'h0c, 32'hffff_fffc, 1, 32'hdead_beef), 32'hbfc0_0380);
      wait_done();

      // event during FLUSH of the 3-cycle unit is ignored
      issue(2'b10, 1, 5'h08, 0, 0, 0, 32'h8000_5000, 32'h0, 32'h0,
            mk(0, 1, 0, 5'h08, 32'h8000_5000, 0, 32'h0), 32'hbfc0_0380);
      drive(2'b10, 1, 5'h09, 0, 0, 0, 32'h8000_5004, 32'h0, 32'h0);
      @(posedge clk); #1;
      clear_in();
      wait_done();

      // invalid WB slot raises nothing
      drive(2'b00, 1, 5'h09, 1, 1, 0, 32'h8000_6000, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      clear_in();

      // reset while holding a redirect drops it
      rdy = 2'b01;
      issue(2'b10, 0, 5'h00, 1, 0, 0, 32'h8000_8000, 32'h8000_4000, 32'h0,
            mk(0, 0, 1, 5'h00, 32'h8000_8000, 0, 32'h0), 32'h8000_4000);
      wait_rv(1);
      #2;
      resetn = 1'b0;
      #1;
      chk_zero("reset_mid_redirect");
      sq1.delete(); rq1.delete();
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      rdy = 2'b11;

      // recovery after reset
      issue(2'b11, 1, 5'h08, 0, 0, 0, 32'h8000_9000, 32'h0, 32'h0,
            mk(0, 1, 0, 5'h08, 32'h8000_9000, 0, 32'h0), 32'hbfc0_0380);
      wait_done();

      chk("scoreboard_empty", 128'(sq0.size() + sq1.size() + rq0.size() + rq1.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
